// File: rtl/serial_reg_responder.sv
// serial_reg_responder: decodes 'R'/'W' register frames from the serial byte stream and replies.
// Optional feature macro SERIAL_WRITE_ACK_EN: acknowledge every completed write with ACK_BYTE.
module serial_reg_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
`ifdef SERIAL_WRITE_ACK_EN
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
`endif
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       rx_drop,
  output logic       frame_err
);

  localparam int unsigned        TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};
  localparam logic [7:0]         CMD_READ   = 8'h52;
  localparam logic [7:0]         CMD_WRITE  = 8'h57;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_GET_ADDR   = 4'd1,
    ST_GET_DATA   = 4'd2,
    ST_WR_ISSUE   = 4'd3,
    ST_RD_ISSUE   = 4'd4,
    ST_RD_CAPTURE = 4'd5,
    ST_TX_SEND    = 4'd6,
    ST_TX_GUARD   = 4'd7,
    ST_TX_WAIT    = 4'd8
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic               is_write_r;
  logic               rd_pending_r;
  logic [TIMER_W-1:0] timer_r;
  logic               is_cmd_s;
  logic               in_frame_s;
  logic               timeout_s;

  logic [7:0] tx_data_s;
  logic       new_tx_data_s;
  logic [7:0] reg_addr_s;
  logic [7:0] reg_wdata_s;
  logic       reg_we_s;
  logic       reg_re_s;
  logic       busy_s;
  logic       rx_drop_s;
  logic       frame_err_s;

  assign is_cmd_s   = (rx_data == CMD_READ) || (rx_data == CMD_WRITE);
  assign in_frame_s = (state_r == ST_GET_ADDR) || (state_r == ST_GET_DATA);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_s  = in_frame_s && !new_rx_data && (timer_r == TIMER_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (new_rx_data) begin
          next_state_s = is_cmd_s ? ST_GET_ADDR : ST_TX_SEND;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GET_ADDR: begin
        if (new_rx_data) begin
          next_state_s = is_write_r ? ST_GET_DATA : ST_RD_ISSUE;
        end else if (timeout_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GET_ADDR;
        end
      end
      ST_GET_DATA: begin
        if (new_rx_data) begin
          next_state_s = ST_WR_ISSUE;
        end else if (timeout_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GET_DATA;
        end
      end
`ifdef SERIAL_WRITE_ACK_EN
      ST_WR_ISSUE:   next_state_s = ST_TX_SEND;
`else
      ST_WR_ISSUE:   next_state_s = ST_IDLE;
`endif
      ST_RD_ISSUE:   next_state_s = ST_RD_CAPTURE;
      ST_RD_CAPTURE: next_state_s = ST_TX_SEND;
      ST_TX_SEND: begin
        if (!tx_busy) begin
          next_state_s = ST_TX_GUARD;
        end else begin
          next_state_s = ST_TX_SEND;
        end
      end
      ST_TX_GUARD:   next_state_s = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_TX_WAIT;
        end
      end
      default:       next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    tx_data_s     = tx_data;
    new_tx_data_s = 1'b0;
    reg_addr_s    = reg_addr;
    reg_wdata_s   = reg_wdata;
    reg_we_s      = 1'b0;
    reg_re_s      = 1'b0;
    rx_drop_s     = 1'b0;
    frame_err_s   = timeout_s;
    busy_s        = (next_state_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (new_rx_data && !is_cmd_s) begin
          tx_data_s = NAK_BYTE;
        end else begin
          tx_data_s = tx_data;
        end
      end
      ST_GET_ADDR: begin
        if (new_rx_data) begin
          reg_addr_s = rx_data;
        end else begin
          reg_addr_s = reg_addr;
        end
      end
      ST_GET_DATA: begin
        if (new_rx_data) begin
          reg_wdata_s = rx_data;
        end else begin
          reg_wdata_s = reg_wdata;
        end
      end
      ST_WR_ISSUE: begin
        reg_we_s  = 1'b1;
        rx_drop_s = new_rx_data;
`ifdef SERIAL_WRITE_ACK_EN
        tx_data_s = ACK_BYTE;
`endif
      end
      ST_RD_ISSUE: begin
        reg_re_s  = 1'b1;
        rx_drop_s = new_rx_data;
      end
      ST_RD_CAPTURE: begin
        rx_drop_s = new_rx_data;
      end
      ST_TX_SEND: begin
        new_tx_data_s = !tx_busy;
        rx_drop_s     = new_rx_data;
        // reg_re leaves through a register, so read data lands one cycle after RD_CAPTURE.
        if (rd_pending_r) begin
          tx_data_s = reg_rdata;
        end else begin
          tx_data_s = tx_data;
        end
      end
      ST_TX_GUARD, ST_TX_WAIT: begin
        rx_drop_s = new_rx_data;
      end
      default: begin
        rx_drop_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wdata   <= 8'h00;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      busy        <= 1'b0;
      rx_drop     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      tx_data     <= tx_data_s;
      new_tx_data <= new_tx_data_s;
      reg_addr    <= reg_addr_s;
      reg_wdata   <= reg_wdata_s;
      reg_we      <= reg_we_s;
      reg_re      <= reg_re_s;
      busy        <= busy_s;
      rx_drop     <= rx_drop_s;
      frame_err   <= frame_err_s;
    end
  end

  // Opcode latch and read-data-arrival marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_write_r   <= 1'b0;
      rd_pending_r <= 1'b0;
    end else begin
      rd_pending_r <= reg_re;
      if ((state_r == ST_IDLE) && new_rx_data && is_cmd_s) begin
        is_write_r <= (rx_data == CMD_WRITE);
      end else begin
        is_write_r <= is_write_r;
      end
    end
  end

  // Inter-byte timer: runs only inside a partial frame, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= {TIMER_W{1'b0}};
    end else if (!in_frame_s || new_rx_data || timeout_s) begin
      timer_r <= {TIMER_W{1'b0}};
    end else if (timer_r != TIMER_MAX) begin
      timer_r <= timer_r + TIMER_W'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

endmodule

// File: tb/tb_serial_reg_responder.sv
// Self-checking bench for serial_reg_responder: directed frames plus random frames scored
// against a frame-level model (shadow register file, expected strobe/reply lists).
module tb_serial_reg_responder;

  localparam int unsigned TIMEOUT = 100;
  localparam logic [7:0]  NAK     = 8'h15;
  localparam logic [7:0]  ACK     = 8'h06;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       rx_drop;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_strobe = 0;

  logic [7:0] mem    [0:255];
  logic [7:0] shadow [0:255];
  logic       hold_busy;
  int         tx_cnt = 0;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_addr = 8'h00;

  logic [15:0] we_q[$];
  int          we_cyc_q[$];
  logic [7:0]  re_q[$];
  int          re_cyc_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  int          drop_q[$];
  int          ferr_q[$];
  logic [15:0] exp_we[$];
  logic [7:0]  exp_re[$];
  logic [7:0]  exp_tx[$];

  serial_reg_responder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .rx_drop(rx_drop), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: transmitter busy after each start, register file with next-cycle read data.
  assign tx_busy = hold_busy | (tx_cnt != 0);
  always @(negedge clk) begin
    if (rst) tx_cnt <= 0;
    else if (new_tx_data) tx_cnt <= 3;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    reg_rdata <= rd_pend ? mem[rd_addr] : 8'hEE;
    rd_pend   <= reg_re;
    rd_addr   <= reg_addr;
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  // Event monitor.
  always @(negedge clk) begin
    if (reg_we)      begin we_q.push_back({reg_addr, reg_wdata}); we_cyc_q.push_back(cyc); end
    if (reg_re)      begin re_q.push_back(reg_addr); re_cyc_q.push_back(cyc); end
    if (new_tx_data) begin tx_q.push_back(tx_data); tx_cyc_q.push_back(cyc); end
    if (rx_drop)     drop_q.push_back(cyc);
    if (frame_err)   ferr_q.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; new_rx_data = 1'b1; last_strobe = cyc;
    @(negedge clk);
    new_rx_data = 1'b0; rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    we_q.delete(); we_cyc_q.delete(); re_q.delete(); re_cyc_q.delete();
    tx_q.delete(); tx_cyc_q.delete(); drop_q.delete(); ferr_q.delete();
    exp_we.delete(); exp_re.delete(); exp_tx.delete();
  endtask

  task automatic wait_quiet(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && !tx_busy && !new_tx_data) done = 1'b1;
    end
    idle(3);
    check({tag, ":quiet"}, 32'(done), 32'd1);
  endtask

  task automatic compare_events(input string tag);
    check({tag, ":we_n"}, we_q.size(), exp_we.size());
    for (int i = 0; i < we_q.size() && i < exp_we.size(); i++) check({tag, ":we"}, we_q[i], exp_we[i]);
    check({tag, ":re_n"}, re_q.size(), exp_re.size());
    for (int i = 0; i < re_q.size() && i < exp_re.size(); i++) check({tag, ":re"}, re_q[i], exp_re[i]);
    check({tag, ":tx_n"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++) check({tag, ":tx"}, tx_q[i], exp_tx[i]);
  endtask

  // kind 0 = read, 1 = write, 2 = unknown command byte a.
  task automatic run_frame(input string tag, input int kind, input logic [7:0] a,
                           input logic [7:0] d, input int gap);
    clear_all();
    if (kind == 0) begin
      send(8'h52); idle(gap); send(a);
      exp_re.push_back(a); exp_tx.push_back(shadow[a]);
    end else if (kind == 1) begin
      send(8'h57); idle(gap); send(a); idle(gap); send(d);
      exp_we.push_back({a, d}); shadow[a] = d;
`ifdef SERIAL_WRITE_ACK_EN
      exp_tx.push_back(ACK);
`endif
    end else begin
      send(a);
      exp_tx.push_back(NAK);
    end
    wait_quiet(tag);
    compare_events(tag);
    check({tag, ":drop_n"}, drop_q.size(), 32'd0);
    check({tag, ":ferr_n"}, ferr_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] a;
    logic [7:0] d;
    int k;
    int s;
    rst = 1'b1; rx_data = 8'h00; new_rx_data = 1'b0; hold_busy = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom); mem[i] <= v; shadow[i] = v;
    end
    mem[8'h10] <= 8'hA5; shadow[8'h10] = 8'hA5;
    idle(3);

    check("rst:tx_data", tx_data, 32'd0);
    check("rst:new_tx_data", new_tx_data, 32'd0);
    check("rst:reg_addr", reg_addr, 32'd0);
    check("rst:reg_wdata", reg_wdata, 32'd0);
    check("rst:reg_we", reg_we, 32'd0);
    check("rst:reg_re", reg_re, 32'd0);
    check("rst:busy", busy, 32'd0);
    check("rst:rx_drop", rx_drop, 32'd0);
    check("rst:frame_err", frame_err, 32'd0);
    rst = 1'b0;
    idle(2);

    // Read with latency.
    run_frame("read10", 0, 8'h10, 8'h00, 0);
    if (re_cyc_q.size() > 0) check("read10:re_lat", re_cyc_q[0] - last_strobe, 32'd2);
    if (tx_cyc_q.size() > 0) check("read10:tx_lat", tx_cyc_q[0] - last_strobe, 32'd4);

    // Write with latency.
    run_frame("write20", 1, 8'h20, 8'h3C, 0);
    if (we_cyc_q.size() > 0) check("write20:we_lat", we_cyc_q[0] - last_strobe, 32'd2);
    run_frame("readback20", 0, 8'h20, 8'h00, 1);

    // Unknown command then a normal read.
    run_frame("badcmd41", 2, 8'h41, 8'h00, 0);
    run_frame("read10_after_bad", 0, 8'h10, 8'h00, 0);

    // Timeout after opcode+address.
    clear_all();
    send(8'h57); send(8'h20); s = last_strobe;
    idle(110);
    check("timeout:ferr_n", ferr_q.size(), 32'd1);
    if (ferr_q.size() > 0) check("timeout:ferr_lat", ferr_q[0] - s, 32'd101);
    check("timeout:we_n", we_q.size(), 32'd0);
    check("timeout:tx_n", tx_q.size(), 32'd0);
    check("timeout:busy", busy, 32'd0);
    run_frame("read20_after_timeout", 0, 8'h20, 8'h00, 0);

    // Byte on the expiry cycle is accepted.
    clear_all();
    send(8'h57); idle(98); send(8'h30); send(8'h5A);
    wait_quiet("edge_accept");
    check("edge_accept:ferr_n", ferr_q.size(), 32'd0);
    exp_we.push_back({8'h30, 8'h5A}); shadow[8'h30] = 8'h5A;
`ifdef SERIAL_WRITE_ACK_EN
    exp_tx.push_back(ACK);
`endif
    compare_events("edge_accept");

    // One cycle later the frame is already gone; the byte is an unknown command.
    clear_all();
    send(8'h57); idle(99); send(8'h20);
    wait_quiet("edge_late");
    check("edge_late:ferr_n", ferr_q.size(), 32'd1);
    exp_tx.push_back(NAK);
    compare_events("edge_late");

    // Overrun while the reply is held by a busy transmitter.
    clear_all();
    hold_busy = 1'b1;
    send(8'h52); send(8'h10);
    idle(4);
    send(8'h52);
    idle(3);
    check("overrun:drop_n", drop_q.size(), 32'd1);
    if (drop_q.size() > 0) check("overrun:drop_lat", drop_q[0] - last_strobe, 32'd1);
    check("overrun:tx_held", tx_q.size(), 32'd0);
    check("overrun:busy_held", busy, 32'd1);
    hold_busy = 1'b0;
    wait_quiet("overrun");
    exp_re.push_back(8'h10); exp_tx.push_back(8'hA5);
    compare_events("overrun");
    check("overrun:idle", busy, 32'd0);

    // Reset in the middle of a write frame.
    clear_all();
    send(8'h57); send(8'h20);
    idle(1);
    check("rstmid:pre_busy", busy, 32'd1);
    check("rstmid:pre_addr", reg_addr, 32'h20);
    rst = 1'b1;
    #1;
    check("rstmid:outputs", {2'b00, tx_data, new_tx_data, reg_addr, reg_wdata,
                             reg_we, reg_re, busy, rx_drop, frame_err}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);
    check("rstmid:we_n", we_q.size(), 32'd0);
    run_frame("read20_after_rst", 0, 8'h20, 8'h00, 0);

    // Random frames against the shadow model.
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 99);
      a = 8'($urandom);
      d = 8'($urandom);
      if (k < 50) begin
        run_frame("rnd_read", 0, a, d, $urandom_range(0, 3));
      end else if (k < 85) begin
        run_frame("rnd_write", 1, a, d, $urandom_range(0, 3));
      end else begin
        while (a == 8'h52 || a == 8'h57) a = 8'($urandom);
        run_frame("rnd_bad", 2, a, d, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
